fifo_read_arbiter: RTL and testbench
====================================

FIFO_READ_ARBITER -- requirements
Module: fifo_read_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 4, number of 32-bit source FIFOs (1..16).
REQ-002 SHALL have parameter MAX_BURST, default 16, max words per grant (1..255).
REQ-003 SHALL have port BUS_CLK  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port SRC_EMPTY  in  N_SRC  per-source FWFT empty flag.
REQ-006 SHALL have port SRC_DATA  in  32*N_SRC  per-source head word; source i at bits [32i+31:32i].
REQ-007 SHALL have port SRC_READ  out  N_SRC  per-source pop strobe, one-hot or zero.
REQ-008 SHALL have port SRC_ENABLE  in  N_SRC  configuration mask; disabled sources never granted.
REQ-009 SHALL have port OUT_EMPTY  out  1  low when OUT_DATA holds a valid word.
REQ-010 SHALL have port OUT_DATA  out  32  FWFT output word.
REQ-011 SHALL have port OUT_READ  in  1  downstream pop; consumes OUT_DATA this cycle.
REQ-012 SHALL have port GRANT_ID  out  clog2(N_SRC) (min 1)  index of current or last grant.
REQ-013 SHALL have port READ_ERROR_CNT  out  8  saturating count of OUT_READ while OUT_EMPTY.

Function
REQ-014 SHALL implement states IDLE and GRANT, plus registers grant (index), rr_ptr, burst_cnt (8 bit), out_valid, out_word.
REQ-015 Eligible(i) SHALL be SRC_ENABLE[i] & !SRC_EMPTY[i].
REQ-016 In IDLE, if any source eligible, SHALL load grant with the first eligible index searching rr_ptr, rr_ptr+1, ... mod N_SRC, clear burst_cnt, enter GRANT next cycle; else stay IDLE.
REQ-017 Holding register SHALL accept when (!out_valid | OUT_READ).
REQ-018 In GRANT, SRC_READ[grant] SHALL be asserted combinationally when accept & !SRC_EMPTY[grant] & SRC_ENABLE[grant] & burst_cnt < MAX_BURST; all other SRC_READ bits 0.
REQ-019 On each SRC_READ pulse, out_word SHALL load SRC_DATA of grant, out_valid set, burst_cnt incremented, all at the same edge.
REQ-020 When OUT_READ & out_valid and no load in the same cycle, out_valid SHALL clear.
REQ-021 OUT_EMPTY SHALL equal !out_valid; OUT_DATA SHALL equal out_word; latency source head to OUT_DATA is 1 cycle.
REQ-022 GRANT SHALL release to IDLE when burst_cnt reaches MAX_BURST, when SRC_EMPTY[grant] is high with no pop that cycle, or when SRC_ENABLE[grant] is low.
REQ-023 On release, rr_ptr SHALL become (grant+1) mod N_SRC; exactly one IDLE arbitration cycle follows every release.
REQ-024 Sustained throughput within a grant SHALL be one word per cycle when OUT_READ held high.
REQ-025 SRC_ENABLE deasserted mid-burst SHALL stop pops the same cycle; the word already in out_word SHALL still be delivered.
REQ-026 With N_SRC=1, rr_ptr SHALL stay 0 and behaviour SHALL reduce to burst-limited pass-through.
REQ-027 READ_ERROR_CNT SHALL increment when OUT_READ & !out_valid, saturating at 8'hFF.
REQ-028 GRANT_ID SHALL hold the last grant value while in IDLE.

Reset
REQ-029 On RST: state IDLE, grant 0, rr_ptr 0, burst_cnt 0, out_valid 0 (OUT_EMPTY=1), out_word 0, READ_ERROR_CNT 0, SRC_READ 0.
REQ-030 RST mid-burst SHALL discard the held word; no SRC_READ SHALL assert during the RST cycle.

Structure
REQ-031 Package fifo_arb_pkg SHALL hold the state enum (IDLE, GRANT), the index-width function and the 32-bit word width constant.
REQ-032 Sub-module rr_select SHALL implement the rotating-base first-eligible search (inputs eligible mask, base; outputs index, any).

Verification
REQ-033 Src0 and src2 enabled, each holding 40 words, OUT_READ=1, MAX_BURST=16 -> order src0x16, src2x16, src0x16, src2x16, src0x8, src2x8; one bubble cycle between bursts.
REQ-034 Single source, 5 words, OUT_READ toggling 1/0 -> 5 words delivered in order, no duplication, no SRC_READ while holding reg full and OUT_READ=0.
REQ-035 SRC_ENABLE[1] cleared after 3rd word of burst from src1 -> exactly 3 words from src1, then grant moves to next eligible, rr_ptr=2.
REQ-036 OUT_READ pulsed 300 times with all sources empty -> READ_ERROR_CNT=255, OUT_EMPTY=1, SRC_READ=0 throughout.
REQ-037 RST asserted mid-burst with out_valid=1 -> next cycle OUT_EMPTY=1, state IDLE, rr_ptr=0, arbitration restarts at src0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO read arbiter: arbitration states,
// datapath word width and the grant-index width helper.
package fifo_arb_pkg;

  localparam int WORD_W = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // A single source still needs a one-bit index so ports never collapse to zero width.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_read_arbiter_rr_select.sv
// Rotating-base priority search: returns the first eligible source found
// when scanning base, base+1, ... modulo N_SRC.
module rr_select
  import fifo_arb_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0]            eligible,
  input  logic [idx_width(N_SRC)-1:0] base,
  output logic [idx_width(N_SRC)-1:0] index,
  output logic                        any
);

  localparam int IDX_W = idx_width(N_SRC);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves a value held and a latch is never inferred.
  always_comb begin
    int idx;
    index = '0;
    any   = 1'b0;
    idx   = 0;
    // Scan from the far end back toward base so the nearest hit wins last.
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = (int'(base) + k) % N_SRC;
      if (eligible[idx]) begin
        index = IDX_W'(idx);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Round-robin, burst-limited arbiter that drains N_SRC first-word-fall-through
// FIFOs into a single one-word FWFT holding register.
module fifo_read_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                        BUS_CLK,
  input  logic                        RST,
  input  logic [N_SRC-1:0]            SRC_EMPTY,
  input  logic [WORD_W*N_SRC-1:0]     SRC_DATA,
  output logic [N_SRC-1:0]            SRC_READ,
  input  logic [N_SRC-1:0]            SRC_ENABLE,
  output logic                        OUT_EMPTY,
  output logic [WORD_W-1:0]           OUT_DATA,
  input  logic                        OUT_READ,
  output logic [idx_width(N_SRC)-1:0] GRANT_ID,
  output logic [7:0]                  READ_ERROR_CNT
);

  localparam int               IDX_W       = idx_width(N_SRC);
  localparam logic [7:0]       BURST_LIMIT = 8'(MAX_BURST);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_SRC - 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] rr_ptr;
  logic [7:0]       burst_cnt;
  logic             out_valid;
  logic [WORD_W-1:0] out_word;
  logic [7:0]       err_cnt;

  logic [N_SRC-1:0] eligible;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic             accept;
  logic             cur_empty;
  logic             cur_en;
  logic [WORD_W-1:0] cur_data;
  logic             pop;
  logic [8:0]       burst_after;
  logic             release_grant;
  logic [IDX_W-1:0] next_base;

  assign eligible  = SRC_ENABLE & ~SRC_EMPTY;
  assign accept    = ~out_valid | OUT_READ;
  assign cur_empty = SRC_EMPTY[grant];
  assign cur_en    = SRC_ENABLE[grant];
  assign cur_data  = SRC_DATA[int'(grant)*WORD_W +: WORD_W];

  // RST gates the pop so a source is never drained while the word would be discarded.
  assign pop = (state == GRANT) & ~RST & accept & ~cur_empty & cur_en &
               (burst_cnt < BURST_LIMIT);

  // Release is judged on the count after this cycle's pop, so the last word of a
  // full burst is followed by exactly one arbitration bubble.
  assign burst_after   = {1'b0, burst_cnt} + {8'd0, pop};
  assign release_grant = (burst_after >= {1'b0, BURST_LIMIT}) | ~cur_en | (cur_empty & ~pop);
  assign next_base     = (grant == LAST_IDX) ? '0 : grant + 1'b1;

  rr_select #(
    .N_SRC(N_SRC)
  ) u_rr_select (
    .eligible(eligible),
    .base    (rr_ptr),
    .index   (sel_idx),
    .any     (sel_any)
  );

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (sel_any) state_nxt = GRANT;
      GRANT:   if (release_grant) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    SRC_READ = '0;
    if (pop) SRC_READ[grant] = 1'b1;
  end

  // Grant bookkeeping: grant only moves on arbitration, so it doubles as GRANT_ID.
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      grant     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sel_any) begin
            grant     <= sel_idx;
            burst_cnt <= '0;
          end
        end
        GRANT: begin
          if (pop) burst_cnt <= burst_cnt + 8'd1;
          if (release_grant) rr_ptr <= next_base;
        end
        default: ;
      endcase
    end
  end

  // A load takes priority over a consume: with OUT_READ high the register refills
  // in the same cycle, which keeps throughput at one word per cycle.
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      out_valid <= 1'b0;
      out_word  <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_word  <= cur_data;
    end else if (OUT_READ && out_valid) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      err_cnt <= '0;
    end else if (OUT_READ && !out_valid && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign OUT_EMPTY      = ~out_valid;
  assign OUT_DATA       = out_word;
  assign GRANT_ID       = grant;
  assign READ_ERROR_CNT = err_cnt;

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Self-checking bench for fifo_read_arbiter: directed scenarios plus a random
// phase, all compared every cycle against a transaction-level reference model.
module tb_fifo_read_arbiter;

  localparam int N  = 4;
  localparam int MB = 16;
  localparam int IW = 2;

  logic            BUS_CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    SRC_EMPTY;
  logic [32*N-1:0] SRC_DATA;
  logic [N-1:0]    SRC_READ;
  logic [N-1:0]    SRC_ENABLE;
  logic            OUT_EMPTY;
  logic [31:0]     OUT_DATA;
  logic            OUT_READ;
  logic [IW-1:0]   GRANT_ID;
  logic [7:0]      READ_ERROR_CNT;

  always #5 BUS_CLK = ~BUS_CLK;

  fifo_read_arbiter #(
    .N_SRC    (N),
    .MAX_BURST(MB)
  ) dut (
    .BUS_CLK       (BUS_CLK),
    .RST           (RST),
    .SRC_EMPTY     (SRC_EMPTY),
    .SRC_DATA      (SRC_DATA),
    .SRC_READ      (SRC_READ),
    .SRC_ENABLE    (SRC_ENABLE),
    .OUT_EMPTY     (OUT_EMPTY),
    .OUT_DATA      (OUT_DATA),
    .OUT_READ      (OUT_READ),
    .GRANT_ID      (GRANT_ID),
    .READ_ERROR_CNT(READ_ERROR_CNT)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Source FIFOs live in the bench; the DUT only sees their head and empty flag.
  logic [31:0] fmem[N][256];
  int rdp[N];
  int wrp[N];
  int seqn[N];

  // Reference model: who holds the grant, where the next search starts,
  // words taken in this burst, the one-word output slot and the error count.
  bit          m_busy;
  int          m_grant;
  int          m_rr;
  int          m_cnt;
  bit          m_valid;
  logic [31:0] m_word;
  int          m_err;

  int          cyc;
  int          pop_src[$];
  int          pop_cyc[$];
  logic [31:0] deliv[$];
  int          hold_viol;

  int exp_run_src[6] = '{0, 2, 0, 2, 0, 2};
  int exp_run_len[6] = '{16, 16, 16, 16, 8, 8};

  task automatic push(input int s);
    fmem[s][wrp[s] % 256] = {8'(s), 24'(seqn[s])};
    wrp[s]++;
    seqn[s]++;
  endtask

  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      rdp[i]  = 0;
      wrp[i]  = 0;
      seqn[i] = 0;
    end
  endtask

  task automatic clear_logs();
    pop_src.delete();
    pop_cyc.delete();
    deliv.delete();
    hold_viol = 0;
  endtask

  task automatic model_reset();
    m_busy  = 0;
    m_grant = 0;
    m_rr    = 0;
    m_cnt   = 0;
    m_valid = 0;
    m_word  = '0;
    m_err   = 0;
  endtask

  task automatic drive_sources();
    for (int i = 0; i < N; i++) begin
      SRC_EMPTY[i]        = (rdp[i] == wrp[i]);
      SRC_DATA[32*i +: 32] = SRC_EMPTY[i] ? (32'hDEAD_0000 | 32'(i)) : fmem[i][rdp[i] % 256];
    end
  endtask

  // One clock: inputs were set at the falling edge; outputs are compared 1 ns
  // later, then the model advances at the rising edge.
  task automatic step();
    bit          pop;
    bit          rel;
    bit          found;
    int          g;
    int          idx;
    logic [31:0] exp_read;
    drive_sources();
    #1;
    g   = m_grant;
    pop = !RST && m_busy && (!m_valid || OUT_READ) && !SRC_EMPTY[g] && SRC_ENABLE[g] && (m_cnt < MB);
    exp_read = pop ? (32'd1 << g) : 32'd0;
    check("src_read",  32'(SRC_READ), exp_read);
    check("out_empty", 32'(OUT_EMPTY), 32'(!m_valid));
    check("out_data",  OUT_DATA, m_word);
    check("grant_id",  32'(GRANT_ID), 32'(m_grant));
    check("err_cnt",   32'(READ_ERROR_CNT), 32'(m_err));
    if (SRC_READ != '0 && !OUT_EMPTY && !OUT_READ) hold_viol++;
    if (OUT_READ && !OUT_EMPTY) deliv.push_back(OUT_DATA);
    @(posedge BUS_CLK);
    if (RST) begin
      model_reset();
    end else begin
      if (OUT_READ && !m_valid && m_err < 255) m_err++;
      if (pop) begin
        m_word  = fmem[g][rdp[g] % 256];
        m_valid = 1;
      end else if (OUT_READ && m_valid) begin
        m_valid = 0;
      end
      if (!m_busy) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          idx = (m_rr + k) % N;
          if (!found && SRC_ENABLE[idx] && !SRC_EMPTY[idx]) begin
            found   = 1;
            m_grant = idx;
            m_cnt   = 0;
            m_busy  = 1;
          end
        end
      end else begin
        rel   = (m_cnt + int'(pop) >= MB) || !SRC_ENABLE[g] || (SRC_EMPTY[g] && !pop);
        m_cnt = m_cnt + int'(pop);
        if (rel) begin
          m_busy = 0;
          m_rr   = (g + 1) % N;
        end
      end
    end
    if (pop) begin
      rdp[g]++;
      pop_src.push_back(g);
      pop_cyc.push_back(cyc);
    end
    cyc++;
    @(negedge BUS_CLK);
  endtask

  task automatic reset_dut();
    clear_sources();
    OUT_READ   = 1'b0;
    SRC_ENABLE = '0;
    RST        = 1'b1;
    step();
    RST = 1'b0;
    clear_logs();
  endtask

  function automatic int count_src(input int s);
    int c = 0;
    foreach (pop_src[i]) if (pop_src[i] == s) c++;
    return c;
  endfunction

  initial begin
    int run_src[$];
    int run_len[$];
    int run_first[$];
    int run_last[$];
    int t;

    cyc = 0;
    clear_sources();
    clear_logs();
    RST        = 1'b1;
    OUT_READ   = 1'b0;
    SRC_ENABLE = '0;
    drive_sources();
    @(posedge BUS_CLK);
    @(negedge BUS_CLK);
    model_reset();

    // Reset state
    step();
    step();
    RST = 1'b0;
    step();
    check("rst_out_empty", 32'(OUT_EMPTY), 32'd1);
    check("rst_grant_id", 32'(GRANT_ID), 32'd0);
    check("rst_err_cnt", 32'(READ_ERROR_CNT), 32'd0);
    check("rst_src_read", 32'(SRC_READ), 32'd0);

    // Two sources, 40 words each, bursts limited to 16
    reset_dut();
    SRC_ENABLE = 4'b0101;
    for (int k = 0; k < 40; k++) begin
      push(0);
      push(2);
    end
    OUT_READ = 1'b1;
    t = 0;
    while (pop_src.size() < 80 && t < 400) begin
      step();
      t++;
    end
    check("burst_total_pops", 32'(pop_src.size()), 32'd80);
    foreach (pop_src[i]) begin
      if (i == 0 || pop_src[i] != pop_src[i-1]) begin
        run_src.push_back(pop_src[i]);
        run_len.push_back(0);
        run_first.push_back(pop_cyc[i]);
        run_last.push_back(pop_cyc[i]);
      end
      run_len[run_len.size()-1]++;
      run_last[run_last.size()-1] = pop_cyc[i];
    end
    check("burst_run_count", 32'(run_src.size()), 32'd6);
    for (int r = 0; r < 6 && r < run_src.size(); r++) begin
      check("burst_run_src", 32'(run_src[r]), 32'(exp_run_src[r]));
      check("burst_run_len", 32'(run_len[r]), 32'(exp_run_len[r]));
    end
    for (int r = 0; r < 4 && r + 1 < run_src.size(); r++)
      check("burst_bubble", 32'(run_first[r+1] - run_last[r] - 1), 32'd1);
    for (int k = 0; k < 4; k++) step();

    // Single source with a toggling consumer
    reset_dut();
    SRC_ENABLE = 4'b0010;
    for (int k = 0; k < 5; k++) push(1);
    for (int k = 0; k < 40; k++) begin
      OUT_READ = ~OUT_READ;
      step();
    end
    check("single_deliv_count", 32'(deliv.size()), 32'd5);
    for (int k = 0; k < 5 && k < deliv.size(); k++)
      check("single_deliv_word", deliv[k], 32'h0100_0000 + 32'(k));
    check("single_hold_pop", 32'(hold_viol), 32'd0);

    // Enable of the granted source dropped after its third word
    reset_dut();
    SRC_ENABLE = 4'b0110;
    for (int k = 0; k < 10; k++) begin
      push(1);
      push(2);
    end
    OUT_READ = 1'b1;
    t = 0;
    while (count_src(1) < 3 && t < 50) begin
      step();
      t++;
    end
    SRC_ENABLE = 4'b0100;
    step();
    SRC_ENABLE = 4'b0110;
    t = 0;
    while (pop_src.size() < 4 && t < 20) begin
      step();
      t++;
    end
    check("disable_pops_src1", 32'(count_src(1)), 32'd3);
    check("disable_next_src", 32'(pop_src.size() >= 4 ? pop_src[3] : -1), 32'd2);
    check("disable_grant_id", 32'(GRANT_ID), 32'd2);

    // Reads against an empty output register
    reset_dut();
    SRC_ENABLE = 4'b1111;
    for (int k = 0; k < 300; k++) begin
      OUT_READ = 1'b1;
      step();
      OUT_READ = 1'b0;
      step();
    end
    check("err_saturated", 32'(READ_ERROR_CNT), 32'hFF);
    check("err_out_empty", 32'(OUT_EMPTY), 32'd1);
    check("err_no_pops", 32'(pop_src.size()), 32'd0);

    // Reset in the middle of a burst
    reset_dut();
    SRC_ENABLE = 4'b1111;
    for (int k = 0; k < 20; k++)
      for (int s = 0; s < N; s++) push(s);
    OUT_READ = 1'b1;
    t = 0;
    while (count_src(1) < 2 && t < 100) begin
      step();
      t++;
    end
    check("midrst_valid_before", 32'(OUT_EMPTY), 32'd0);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("midrst_out_empty", 32'(OUT_EMPTY), 32'd1);
    check("midrst_grant_id", 32'(GRANT_ID), 32'd0);
    clear_logs();
    t = 0;
    while (pop_src.size() < 1 && t < 20) begin
      step();
      t++;
    end
    check("midrst_first_src", 32'(pop_src.size() >= 1 ? pop_src[0] : -1), 32'd0);

    // Random traffic, enables, consumer stalls and occasional resets
    reset_dut();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) != 0) begin
        int s;
        s = int'($urandom_range(0, N - 1));
        if (wrp[s] - rdp[s] < 200) push(s);
      end
      if ($urandom_range(0, 15) == 0) SRC_ENABLE = 4'($urandom_range(0, 15));
      OUT_READ = ($urandom_range(0, 3) != 0);
      RST      = ($urandom_range(0, 299) == 0);
      step();
    end
    RST = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
